// File: rtl/imem_fetch_pkg.sv
// Shared types and sizing for the instruction fetch controller and its skid queue.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int FETCH_Q_DEPTH = 2;
    localparam int FETCH_Q_PTR_W = (FETCH_Q_DEPTH > 1) ? $clog2(FETCH_Q_DEPTH) : 1;
    localparam int FETCH_Q_CNT_W = $clog2(FETCH_Q_DEPTH + 1);

    function automatic logic [FETCH_Q_PTR_W-1:0] q_ptr_inc(input logic [FETCH_Q_PTR_W-1:0] p);
        return (p == FETCH_Q_PTR_W'(FETCH_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/imem_fetch_queue.sv
// Small FIFO of fetch entries; accepts a push in the same cycle as a pop when full.
module imem_fetch_queue
    import imem_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_entry,
    output fetch_entry_t             head,
    output logic [FETCH_Q_CNT_W-1:0] count
);

    logic [FETCH_Q_PTR_W-1:0] r_rd_ptr;
    logic [FETCH_Q_PTR_W-1:0] r_wr_ptr;
    logic [FETCH_Q_CNT_W-1:0] r_count;
    logic                     w_do_pop;
    logic                     w_do_push;
    fetch_entry_t             w_entries [FETCH_Q_DEPTH];

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count < FETCH_Q_CNT_W'(FETCH_Q_DEPTH)) || w_do_pop);

    generate
        for (genvar gi = 0; gi < FETCH_Q_DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_entry <= '0;
                end else if (!flush && w_do_push && (r_wr_ptr == FETCH_Q_PTR_W'(gi))) begin
                    r_entry <= push_entry;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop)  r_rd_ptr <= q_ptr_inc(r_rd_ptr);
            if (w_do_push) r_wr_ptr <= q_ptr_inc(r_wr_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = w_entries[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: drives the ROM address, queues fetched words for decode, traps bad PCs.
// Optional performance counters are built when IMEM_FETCH_PERF_EN is defined.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] rom_addr,
    input  logic [31:0] rom_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        busy,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_stalls
);

    fetch_state_t             r_state;
    logic [63:0]              r_fetch_pc;
    logic [63:0]              r_fault_pc;
    logic [FETCH_Q_CNT_W-1:0] w_count;
    fetch_entry_t             w_head;
    fetch_entry_t             w_push_entry;
    logic                     w_legal;
    logic                     w_out_valid;
    logic                     w_pop;
    logic                     w_space;
    logic                     w_push;
    logic                     w_flush;

    // 65-bit sum so a PC near 2^64 cannot wrap into the legal range.
    assign w_legal     = (r_fetch_pc[1:0] == 2'b00) &&
                         (({1'b0, r_fetch_pc} + 65'd3) < 65'(MEM_SIZE));
    assign w_out_valid = (w_count != '0);
    assign w_flush     = stop || redirect_valid;
    assign w_pop       = w_out_valid && out_ready && !w_flush;
    assign w_space     = (w_count < FETCH_Q_CNT_W'(FETCH_Q_DEPTH)) || w_pop;
    assign w_push      = (r_state == RUN) && !w_flush && w_legal && w_space;
    assign w_push_entry = '{pc: r_fetch_pc, instr: rom_instr};

    imem_fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (w_flush),
        .push_entry (w_push_entry),
        .head       (w_head),
        .count      (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_fault_pc <= '0;
        end else if (stop) begin
            r_state <= IDLE;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                if (r_state == FAULT) r_state <= RUN;
            end
            case (r_state)
                IDLE: if (start) r_state <= RUN;
                RUN: begin
                    if (!redirect_valid && !w_legal) begin
                        r_state    <= FAULT;
                        r_fault_pc <= r_fetch_pc;
                    end else if (w_push) begin
                        r_fetch_pc <= r_fetch_pc + 64'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr  = r_fetch_pc;
    assign out_valid = w_out_valid;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign busy      = (r_state == RUN);
    assign fault     = (r_state == FAULT);
    assign fault_pc  = r_fault_pc;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] r_perf_fetches;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetches <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_push && (r_perf_fetches != '1)) r_perf_fetches <= r_perf_fetches + 1'b1;
            if (w_out_valid && !out_ready && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end

    assign perf_fetches = r_perf_fetches;
    assign perf_stalls  = r_perf_stalls;
`else
    assign perf_fetches = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: scoreboard for streams, table for PC legality.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] rom_addr;
    logic [31:0] rom_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        busy;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] perf_fetches;
    logic [31:0] perf_stalls;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } sb_t;
    sb_t sbq[$];
    logic sb_en = 1'b0;

    typedef struct {
        logic [63:0] pc;
        logic        exp_fault;
    } vec_t;
    vec_t vecs[8];

`ifdef IMEM_FETCH_PERF_EN
    localparam logic [31:0] EXP_STALLS  = 32'd4;
    localparam logic [31:0] EXP_FETCHES = 32'd6;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FETCHES = 32'd0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return 32'hA0 + 32'(a[9:2]);
    endfunction

    assign rom_instr = rom_word(rom_addr);

    imem_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .busy           (busy),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .perf_fetches   (perf_fetches),
        .perf_stalls    (perf_stalls)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic sb_push(input logic [63:0] pc);
        sb_t e;
        e.pc    = pc;
        e.instr = rom_word(pc);
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: a pop happens on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (sb_en && !reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra: got pc 0x%0h, expected no delivery", out_pc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
                $display("pop pc=0x%0h instr=0x%0h", out_pc, out_instr);
            end
        end
    end

    initial begin
        vecs[0] = '{pc: 64'h3FC,                 exp_fault: 1'b0};
        vecs[1] = '{pc: 64'h400,                 exp_fault: 1'b1};
        vecs[2] = '{pc: 64'h6,                   exp_fault: 1'b1};
        vecs[3] = '{pc: 64'h3FD,                 exp_fault: 1'b1};
        vecs[4] = '{pc: 64'h3F8,                 exp_fault: 1'b0};
        vecs[5] = '{pc: 64'hFFFF_FFFF_FFFF_FFFC, exp_fault: 1'b1};
        vecs[6] = '{pc: 64'h100,                 exp_fault: 1'b0};
        vecs[7] = '{pc: 64'h2,                   exp_fault: 1'b1};

        // Reset values
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_rom_addr", rom_addr, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_fault_pc", fault_pc, 64'd0);
        chk("rst_perf_fetches", {32'd0, perf_fetches}, 64'd0);
        chk("rst_perf_stalls", {32'd0, perf_stalls}, 64'd0);
        step();
        reset = 1'b0;

        // Streaming from reset with out_ready high
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_latency_valid", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 6; i++) sb_push(64'(i * 4));
        sb_en = 1'b1;
        repeat (7) step();
        sb_en = 1'b0;
        chk("stream_all_delivered", 64'(sbq.size()), 64'd0);
        chk("stream_busy", {63'd0, busy}, 64'd1);
        sbq.delete();

        // Stall with full queue, then drain
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_out_pc", out_pc, 64'd0);
        chk("stall_out_instr", {32'd0, out_instr}, 64'hA0);
        chk("stall_rom_addr", rom_addr, 64'd8);
        chk("stall_perf_stalls", {32'd0, perf_stalls}, {32'd0, EXP_STALLS});
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb_push(64'(i * 4));
        sb_en = 1'b1;
        repeat (4) step();
        sb_en = 1'b0;
        chk("drain_all_delivered", 64'(sbq.size()), 64'd0);
        chk("drain_perf_fetches", {32'd0, perf_fetches}, {32'd0, EXP_FETCHES});
        chk("drain_perf_stalls", {32'd0, perf_stalls}, {32'd0, EXP_STALLS});
        sbq.delete();

        // Redirect while queue full
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        chk("redir_bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("redir_rom_addr", rom_addr, 64'h40);
        step();
        chk("redir_valid", {63'd0, out_valid}, 64'd1);
        chk("redir_out_pc", out_pc, 64'h40);
        chk("redir_out_instr", {32'd0, out_instr}, 64'hB0);

        // PC legality table
        for (int v = 0; v < 8; v++) begin
            redirect_valid = 1'b1;
            redirect_pc = vecs[v].pc;
            step();
            redirect_valid = 1'b0;
            chk("vec_bubble_valid", {63'd0, out_valid}, 64'd0);
            chk("vec_rom_addr", rom_addr, vecs[v].pc);
            step();
            chk("vec_fault", {63'd0, fault}, {63'd0, vecs[v].exp_fault});
            chk("vec_busy", {63'd0, busy}, {63'd0, !vecs[v].exp_fault});
            chk("vec_valid", {63'd0, out_valid}, {63'd0, !vecs[v].exp_fault});
            if (vecs[v].exp_fault) begin
                chk("vec_fault_pc", fault_pc, vecs[v].pc);
            end else begin
                chk("vec_out_pc", out_pc, vecs[v].pc);
                chk("vec_out_instr", {32'd0, out_instr}, {32'd0, rom_word(vecs[v].pc)});
            end
            $display("vec %0d pc=0x%0h fault=%0b valid=%0b", v, vecs[v].pc, fault, out_valid);
        end

        // Stream off the end of memory, then recover
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3FC;
        step();
        redirect_valid = 1'b0;
        chk("end_fault_cleared", {63'd0, fault}, 64'd0);
        step();
        chk("end_valid", {63'd0, out_valid}, 64'd1);
        chk("end_out_pc", out_pc, 64'h3FC);
        step();
        chk("end_fault", {63'd0, fault}, 64'd1);
        chk("end_fault_pc", fault_pc, 64'h400);
        chk("end_busy", {63'd0, busy}, 64'd0);
        chk("end_drained", {63'd0, out_valid}, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        chk("recover_fault", {63'd0, fault}, 64'd0);
        chk("recover_busy", {63'd0, busy}, 64'd1);
        step();
        chk("recover_out_pc", out_pc, 64'h0);
        chk("recover_out_instr", {32'd0, out_instr}, 64'hA0);

        // Stop beats a simultaneous start and leaves the fetch PC alone
        out_ready = 1'b0;
        repeat (2) step();
        chk("prestop_rom_addr", rom_addr, 64'd8);
        stop = 1'b1;
        start = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_valid", {63'd0, out_valid}, 64'd0);
        chk("stop_rom_addr", rom_addr, 64'd8);
        step();
        chk("stop_idle_no_push", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset between edges
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("pre_areset_valid", {63'd0, out_valid}, 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", {63'd0, out_valid}, 64'd0);
        chk("areset_busy", {63'd0, busy}, 64'd0);
        chk("areset_fault", {63'd0, fault}, 64'd0);
        chk("areset_rom_addr", rom_addr, 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_areset_busy", {63'd0, busy}, 64'd0);
        chk("post_areset_valid", {63'd0, out_valid}, 64'd0);
        chk("post_areset_rom_addr", rom_addr, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer that owns the instruction ROM address port. It holds the fetch PC, issues one word-aligned read per cycle into the combinational instruction memory, and buffers results in a 2-entry skid queue behind a valid/ready handshake to decode. It handles branch redirects, flushes the queue on redirect or stop, and traps out-of-range or misaligned fetches instead of letting the ROM return X.

## Interface
Parameters:
- MEM_SIZE, 1024: instruction memory size in bytes; power of two, >4.
- RESET_PC, 64'd0: fetch PC loaded on reset.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; IDLE→RUN.
- stop  in  1  level; RUN/FAULT→IDLE; flushes queue.
- redirect_valid  in  1  load a new fetch PC this cycle.
- redirect_pc  in  64  byte address of the redirect target.
- rom_addr  out  64  address to instruction ROM; equals fetch PC (registered).
- rom_instr  in  32  combinational ROM data for rom_addr.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  64  PC of head entry.
- out_instr  out  32  instruction of head entry.
- busy  out  1  state is RUN.
- fault  out  1  state is FAULT.
- fault_pc  out  64  fetch PC that caused the fault.
- perf_fetches  out  32  count of queue pushes (see Configuration).
- perf_stalls  out  32  count of cycles with out_valid=1 and out_ready=0.

## Operation
- States: IDLE, RUN, FAULT. The state leaves reset as IDLE.
- IDLE: no pushes.
  - start → RUN.
  - A redirect loads the fetch PC and the state stays IDLE.
- RUN: the fetch PC is legal when fetch_pc[1:0]==0 and fetch_pc+3 < MEM_SIZE.
  - If legal and there is space, push {fetch_pc, rom_instr} and advance the fetch PC by 4.
  - If illegal, do not push; go to FAULT; capture fault_pc.
- Space exists when count<2, or when count==2 and a pop happens in the same cycle.
- Pop: out_valid && out_ready. out_* always present the head entry.
- FAULT: no pushes. Queued entries stay drainable.
  - A redirect → RUN, and fault clears.
  - If the new PC is also illegal, re-enter FAULT on the next RUN cycle.
- Priority, highest first:
  1. reset
  2. stop: → IDLE, flush, fetch PC unchanged
  3. redirect: flush, fetch PC = redirect_pc, no push, pop ignored
  4. normal push/pop
- start in RUN or FAULT is ignored. stop overrides a simultaneous start.
- The fetch PC is 64-bit. +4 wraps modulo 2^64; the bounds check catches it before that.

## Timing
- Reset values:
  - out_valid=0, out_pc=0, out_instr=0, rom_addr=RESET_PC.
  - busy=0, fault=0, fault_pc=0, perf_*=0.
- start sampled at edge E0 → RUN. The first push is at E1, so out_valid=1 after E1 (2-edge start latency).
- Redirect sampled at edge R: the queue is empty after R and the new PC is pushed at R+1. That is one bubble.
- Steady state: one instruction per cycle with out_ready held high.
- Full queue with out_ready=0: rom_addr holds and out_* hold stable. After out_ready rises, one entry pops per cycle.
- fault rises on the edge after the illegal PC is presented. busy falls on that same edge.
- Asynchronous reset mid-RUN: outputs go to reset values immediately, without waiting for an edge.

## Configuration
- IMEM_FETCH_PERF_EN defined: perf_fetches increments per push; perf_stalls increments per stall cycle. Both saturate at 2^32-1 and clear only on reset.
- IMEM_FETCH_PERF_EN undefined: counter logic is not built; both ports are tied to 0.

## Structure
- Package imem_fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, FAULT}.
  - fetch_entry_t struct {pc[63:0], instr[31:0]}.
  - FETCH_Q_DEPTH=2.
- Sub-module imem_fetch_queue: 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count.
  - Supports simultaneous push+pop when full.
- The top level holds the state machine, fetch PC, legality check and perf counters.

## Test plan
- Reset, start, out_ready=1, ROM words 0..3 = 0xA0..0xA3 → out_pc 0,4,8,12 on consecutive cycles with matching instr; busy=1.
- out_ready=0 for 5 cycles after start → queue holds pc 0,4; rom_addr stays 8; perf_stalls=4 (macro on) or 0 (macro off).
- Redirect to 0x40 while queue holds 2 entries → next cycle out_valid=0; the following cycle out_pc=0x40.
- With MEM_SIZE=1024, redirect to 0x3FC then stream → 0x3FC delivered; fault=1 with fault_pc=0x400; redirect to 0 → fault=0, out_pc=0.
- Redirect to 0x6 → fault=1, fault_pc=0x6, no push.
- Assert reset asynchronously mid-stream between edges → out_valid, busy and fault drop immediately; after release the state is IDLE and rom_addr=RESET_PC.
